// File: rtl/pe_pkg.sv
// Shared PE-array defaults and mode encoding.
package pe_pkg;

  localparam int unsigned PeDataWidth = 16;
  localparam int unsigned PeAccWidth  = 32;
  localparam int unsigned PeFracBits  = 8;
  localparam int unsigned PePack      = 4;

  // PE operation modes; all three produce accumulator-domain results.
  typedef enum logic [1:0] {
    ModeMac = 2'd0,
    ModeEwm = 2'd1,
    ModeEwa = 2'd2
  } pe_mode_e;

endpackage

// File: rtl/pe_requant.sv
// Combinational requantizer: accumulator domain Q(2F) -> data domain Q(F),
// round-half-up then saturate to the signed DATA_WIDTH range.
module pe_requant
  import pe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = PeDataWidth,
  parameter int unsigned ACC_WIDTH  = PeAccWidth,
  parameter int unsigned FRAC_BITS  = PeFracBits
) (
  input  logic [ACC_WIDTH-1:0]  in_data,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  sat
);

  localparam logic [ACC_WIDTH:0] One = {{ACC_WIDTH{1'b0}}, 1'b1};
  // Half an LSB of the result; collapses to 0 when FRAC_BITS is 0.
  localparam logic [ACC_WIDTH:0] RoundConst = (One << FRAC_BITS) >> 1;
  localparam logic signed [ACC_WIDTH:0] QMax = $signed((One << (DATA_WIDTH - 1)) - One);
  localparam logic signed [ACC_WIDTH:0] QMin = ~QMax;

  logic signed [ACC_WIDTH:0] t;
  logic signed [ACC_WIDTH:0] q_full;

  // One extra bit so the rounding add cannot wrap.
  assign t      = $signed({in_data[ACC_WIDTH-1], in_data}) + $signed(RoundConst);
  assign q_full = t >>> FRAC_BITS;

  // Clip to the output range and flag saturation.
  always_comb begin
    q   = q_full[DATA_WIDTH-1:0];
    sat = 1'b0;
    if (q_full > QMax) begin
      q   = QMax[DATA_WIDTH-1:0];
      sat = 1'b1;
    end else if (q_full < QMin) begin
      q   = QMin[DATA_WIDTH-1:0];
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/pe_result_packer.sv
// Return path: requantize PE results and pack PACK of them per output word.
module pe_result_packer
  import pe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = PeDataWidth,
  parameter int unsigned ACC_WIDTH  = PeAccWidth,
  parameter int unsigned FRAC_BITS  = PeFracBits,
  parameter int unsigned PACK       = PePack
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ACC_WIDTH-1:0]       in_data,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PACK*DATA_WIDTH-1:0] out_data,
  output logic [$clog2(PACK+1)-1:0]  out_lanes,
  output logic                       out_last,
  input  logic                       sat_clr,
  output logic [15:0]                sat_count
);

  localparam int unsigned LaneW = $clog2(PACK + 1);
  localparam logic [LaneW-1:0] LastLane = LaneW'(PACK - 1);

  logic [DATA_WIDTH-1:0] rq_data;
  logic                  rq_sat;

  logic                  s1_valid_q, s1_valid_d;
  logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;
  logic                  s1_sat_q, s1_sat_d;
  logic                  s1_last_q, s1_last_d;

  logic [PACK*DATA_WIDTH-1:0] buf_q, buf_d;
  logic [LaneW-1:0]           cnt_q, cnt_d;
  logic [LaneW-1:0]           lanes_q, lanes_d;
  logic                       out_valid_q, out_valid_d;
  logic                       out_last_q, out_last_d;
  logic [15:0]                sat_cnt_q, sat_cnt_d;

  logic s1_adv;
  logic in_hs;
  logic out_hs;

  pe_requant #(
    .DATA_WIDTH(DATA_WIDTH),
    .ACC_WIDTH (ACC_WIDTH),
    .FRAC_BITS (FRAC_BITS)
  ) u_requant (
    .in_data(in_data),
    .q      (rq_data),
    .sat    (rq_sat)
  );

  // s1 drains whenever the buffer is open or is being emptied this cycle.
  assign s1_adv   = s1_valid_q && (!out_valid_q || out_ready);
  assign in_ready = !s1_valid_q || s1_adv;
  assign in_hs    = in_valid && in_ready;
  assign out_hs   = out_valid_q && out_ready;

  // s1 next state: load on input handshake, empty when it advances.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_sat_d   = s1_sat_q;
    s1_last_d  = s1_last_q;
    if (in_hs) begin
      s1_valid_d = 1'b1;
      s1_data_d  = rq_data;
      s1_sat_d   = rq_sat;
      s1_last_d  = in_last;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  // Pack buffer next state; a pop clears it so lane 0 can be written the same cycle.
  always_comb begin
    buf_d       = buf_q;
    cnt_d       = cnt_q;
    lanes_d     = lanes_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    if (out_hs) begin
      buf_d       = '0;
      lanes_d     = '0;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
    if (s1_adv) begin
      for (int i = 0; i < int'(PACK); i++) begin
        if (cnt_q == LaneW'(i)) buf_d[i*DATA_WIDTH +: DATA_WIDTH] = s1_data_q;
      end
      if (cnt_q == LastLane || s1_last_q) begin
        out_valid_d = 1'b1;
        lanes_d     = cnt_q + LaneW'(1);
        out_last_d  = s1_last_q;
        cnt_d       = '0;
      end else begin
        cnt_d = cnt_q + LaneW'(1);
      end
    end
  end

  // Saturation counter: clear wins, sticks at all-ones.
  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (sat_clr) begin
      sat_cnt_d = '0;
    end else if (s1_adv && s1_sat_q && (sat_cnt_q != 16'hFFFF)) begin
      sat_cnt_d = sat_cnt_q + 16'd1;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_sat_q    <= 1'b0;
      s1_last_q   <= 1'b0;
      buf_q       <= '0;
      cnt_q       <= '0;
      lanes_q     <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      sat_cnt_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_sat_q    <= s1_sat_d;
      s1_last_q   <= s1_last_d;
      buf_q       <= buf_d;
      cnt_q       <= cnt_d;
      lanes_q     <= lanes_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      sat_cnt_q   <= sat_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = buf_q;
  assign out_lanes = lanes_q;
  assign out_last  = out_last_q;
  assign sat_count = sat_cnt_q;

endmodule

// File: tb/tb_pe_result_packer.sv
// Self-checking bench for pe_result_packer with a word-level reference model.
module tb_pe_result_packer;

  localparam int DW = 16;
  localparam int AW = 32;
  localparam int FB = 8;
  localparam int PK = 4;
  localparam int OW = PK * DW;
  localparam int LW = $clog2(PK + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [AW-1:0] in_data = '0;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [OW-1:0] out_data;
  logic [LW-1:0] out_lanes;
  logic          out_last;
  logic          sat_clr = 1'b0;
  logic [15:0]   sat_count;

  pe_result_packer #(
    .DATA_WIDTH(DW),
    .ACC_WIDTH (AW),
    .FRAC_BITS (FB),
    .PACK      (PK)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_lanes(out_lanes),
    .out_last (out_last),
    .sat_clr  (sat_clr),
    .sat_count(sat_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OW-1:0] data;
    int            lanes;
    bit            last;
  } word_t;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  word_t         exp_q[$];
  logic [OW-1:0] m_word = '0;
  int            m_cnt = 0;
  int            m_sat = 0;

  // Observation state
  int            cyc = 0;
  int            acc_cyc[$];
  int            out_cyc[$];
  bit            held = 0;
  logic [OW-1:0] held_data;
  logic [OW-1:0] last_data = '0;
  int            last_lanes = 0;
  bit            last_last = 0;
  bit            rand_rdy = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Requantize by plain arithmetic and append to the word being assembled.
  task automatic model_accept(input logic [AW-1:0] d, input logic l);
    longint        t;
    longint        hi;
    longint        lo;
    logic [DW-1:0] q;
    word_t         w;
    hi = (longint'(1) << (DW - 1)) - 1;
    lo = -hi - 1;
    t  = longint'($signed(d));
    if (FB > 0) t = t + (longint'(1) << (FB - 1));
    t = t >>> FB;
    if (t > hi) begin
      t = hi;
      if (m_sat < 16'hFFFF) m_sat++;
    end else if (t < lo) begin
      t = lo;
      if (m_sat < 16'hFFFF) m_sat++;
    end
    q = t[DW-1:0];
    m_word[m_cnt*DW +: DW] = q;
    m_cnt++;
    if (m_cnt == PK || l) begin
      w.data  = m_word;
      w.lanes = m_cnt;
      w.last  = l;
      exp_q.push_back(w);
      m_word = '0;
      m_cnt  = 0;
    end
  endtask

  // Mid-cycle monitor: signals are stable here until the next rising edge.
  always @(negedge clk) begin
    word_t e;
    if (!rst_n) begin
      held = 0;
    end else begin
      cyc++;
      if (held) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_data", out_data, held_data);
      end
      if (out_valid && out_ready) begin
        out_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_word: got 0x%0h, expected no word", out_data);
        end else begin
          e = exp_q.pop_front();
          check("word_data", out_data, e.data);
          check("word_lanes", 64'(out_lanes), 64'(e.lanes));
          check("word_last", 64'(out_last), 64'(e.last));
        end
        last_data  = out_data;
        last_lanes = int'(out_lanes);
        last_last  = out_last;
      end
      held      = out_valid && !out_ready;
      held_data = out_data;
      if (in_valid && in_ready) begin
        acc_cyc.push_back(cyc);
        model_accept(in_data, in_last);
      end
    end
  end

  // Random downstream backpressure.
  always @(posedge clk) begin
    if (rand_rdy) begin
      #1 out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [AW-1:0] d, input logic l);
    int g;
    g        = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(negedge clk);
    while (!in_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (!in_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout: got in_ready=0, expected 1 within 200 cycles");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = $urandom;
    in_last  = 1'($urandom_range(0, 1));
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((exp_q.size() != 0 || out_valid) && g < 2000) begin
      @(posedge clk);
      #1;
      g++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] rand_data();
    logic [AW-1:0] v;
    case ($urandom_range(0, 4))
      0: v = $urandom;
      1: v = 32'($urandom_range(0, 32'h00FF_FFFF)) - 32'h0080_0000;
      2: begin
        v = $urandom;
        v[7:0] = ($urandom_range(0, 1) != 0) ? 8'h80 : 8'h7F;
        v[31:20] = {12{v[19]}};
      end
      3: v = ($urandom_range(0, 1) != 0) ? 32'h007F_FF7F + 32'($urandom_range(0, 1))
                                         : 32'hFF7F_FF7F + 32'($urandom_range(0, 1));
      default: v = ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
    endcase
    return v;
  endfunction

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_out_lanes", 64'(out_lanes), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Rounding: 2, -1, 0, 1
    send(32'h0000_0180, 1'b0);
    send(32'hFFFF_FE80, 1'b0);
    send(32'h0000_007F, 1'b0);
    send(32'h0000_0080, 1'b0);
    drain();
    check("round_word", last_data, 64'h0001_0000_FFFF_0002);
    check("round_lanes", 64'(last_lanes), 64'd4);
    check("round_last", 64'(last_last), 64'd0);

    // Saturation both ways, closing a 2-lane word
    send(32'h0080_0000, 1'b0);
    send(32'h8000_0000, 1'b1);
    drain();
    check("sat_word", last_data, 64'h0000_0000_8000_7FFF);
    check("sat_lanes", 64'(last_lanes), 64'd2);
    check("sat_last", 64'(last_last), 64'd1);
    check("sat_count_2", 64'(sat_count), 64'd2);
    sat_clr = 1'b1;
    @(posedge clk);
    #1;
    sat_clr = 1'b0;
    m_sat   = 0;
    check("sat_clr", 64'(sat_count), 64'd0);

    // Streaming: 16 back-to-back elements
    acc_cyc.delete();
    out_cyc.delete();
    for (int i = 0; i < 16; i++) send(rand_data(), 1'b0);
    drain();
    check("stream_accepts", 64'(acc_cyc.size()), 64'd16);
    check("stream_words", 64'(out_cyc.size()), 64'd4);
    if (acc_cyc.size() == 16 && out_cyc.size() == 4) begin
      check("stream_no_stall", 64'(acc_cyc[15] - acc_cyc[0]), 64'd15);
      check("stream_latency", 64'(out_cyc[0] - acc_cyc[3]), 64'd2);
      for (int i = 1; i < 4; i++) check("stream_period", 64'(out_cyc[i] - out_cyc[i-1]), 64'd4);
    end

    // Backpressure mid-word
    send(32'h0000_1100, 1'b0);
    send(32'h0000_1200, 1'b0);
    out_ready = 1'b0;
    acc_cyc.delete();
    fork
      begin
        for (int i = 0; i < 8; i++) send(32'h0000_2000 + 32'(i) * 32'h100, i == 7);
      end
      begin
        repeat (12) @(posedge clk);
        #1;
        check("bp_accepts", 64'(acc_cyc.size()), 64'd3);
        check("bp_in_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
      end
    join
    drain();
    check("bp_total", 64'(acc_cyc.size()), 64'd8);

    // Partial flush, then a fresh word starting at lane 0
    send(32'h0000_0100, 1'b0);
    send(32'h0000_0200, 1'b0);
    send(32'h0000_0300, 1'b1);
    drain();
    check("flush_word", last_data, 64'h0000_0003_0002_0001);
    check("flush_lanes", 64'(last_lanes), 64'd3);
    check("flush_last", 64'(last_last), 64'd1);
    send(32'h0000_0500, 1'b1);
    drain();
    check("after_flush_word", last_data, 64'h0000_0000_0000_0005);
    check("after_flush_lanes", 64'(last_lanes), 64'd1);

    // Random traffic with random backpressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      send(rand_data(), $urandom_range(0, 7) == 0);
    end
    send(32'h7FFF_FFFF, 1'b1);
    rand_rdy = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    drain();
    check("rand_sat_count", 64'(sat_count), 64'(m_sat));

    // Reset mid-word
    send(32'h0000_0900, 1'b0);
    send(32'h0000_0A00, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    m_word = '0;
    m_cnt  = 0;
    m_sat  = 0;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_out_data", out_data, 64'd0);
    check("mid_rst_out_lanes", 64'(out_lanes), 64'd0);
    check("mid_rst_out_last", 64'(out_last), 64'd0);
    check("mid_rst_sat_count", 64'(sat_count), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(32'h0000_0300, 1'b0);
    send(32'h0000_0400, 1'b1);
    drain();
    check("post_rst_word", last_data, 64'h0000_0000_0004_0003);
    check("post_rst_lanes", 64'(last_lanes), 64'd2);
    check("post_rst_last", 64'(last_last), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
